// File: rtl/lvds_frame_rx.sv
// Deframer for the 32-bit LVDS I/Q frame format: hunts for frame alignment on
// the DDR dibit stream, confirms lock, and emits I/Q samples, EOM and errors.
module lvds_frame_rx #(
  parameter int LOCK_FRAMES = 2,
  parameter int MISS_LIMIT  = 3,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       rx_d,
  input  logic             rx_d_valid,
  output logic [12:0]      out_i,
  output logic [12:0]      out_q,
  output logic             out_valid,
  output logic             out_eom,
  output logic             locked,
  output logic             frame_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
  typedef enum logic [1:0] {F_BAD, F_DATA, F_EOM, F_IDLE} frame_t;

  state_t            state, state_nx;
  logic [31:0]       sr, sr_nx;
  logic [3:0]        cnt, cnt_nx;
  logic [GOOD_W-1:0] good, good_nx;
  logic [MISS_W-1:0] miss, miss_nx;
  logic [ERR_W-1:0]  err_nx;
  logic [12:0]       i_nx, q_nx;
  logic              valid_nx, eom_nx, ferr_nx, emit;
  logic              boundary;
  frame_t            cls;

  // rx_d[0] arrived first on the wire, so it lands in the more significant slot.
  assign sr_nx    = {sr[29:0], rx_d[0], rx_d[1]};
  assign boundary = (cnt == 4'd15);
  assign locked   = (state == LOCKED);

  always_comb begin
    cls = F_BAD;
    if (sr_nx == 32'h0)
      cls = F_IDLE;
    else if (sr_nx == 32'h8000_4000)
      cls = F_EOM;
    else if (sr_nx[31:30] == 2'b10 && sr_nx[16] && sr_nx[15:14] == 2'b01 && !sr_nx[0])
      cls = F_DATA;
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    good_nx  = good;
    miss_nx  = miss;
    err_nx   = err_count;
    i_nx     = out_i;
    q_nx     = out_q;
    valid_nx = 1'b0;
    eom_nx   = 1'b0;
    ferr_nx  = 1'b0;
    emit     = 1'b0;
    if (rx_d_valid) begin
      cnt_nx = cnt + 4'd1;
      unique case (state)
        HUNT: begin
          if (cls == F_DATA || cls == F_EOM) begin
            cnt_nx  = 4'd0;
            good_nx = GOOD_W'(1);
            if (LOCK_FRAMES <= 1) begin
              state_nx = LOCKED;
              miss_nx  = '0;
              emit     = 1'b1;
            end else begin
              state_nx = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (cls == F_DATA || cls == F_EOM) begin
              good_nx = good + GOOD_W'(1);
              if (good_nx >= GOOD_W'(LOCK_FRAMES)) begin
                state_nx = LOCKED;
                miss_nx  = '0;
                emit     = 1'b1;
              end
            end else if (cls == F_BAD) begin
              state_nx = HUNT;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            if (cls == F_BAD) begin
              ferr_nx = 1'b1;
              if (err_count != '1)
                err_nx = err_count + ERR_W'(1);
              if (miss + MISS_W'(1) >= MISS_W'(MISS_LIMIT)) begin
                state_nx = HUNT;
                miss_nx  = '0;
              end else begin
                miss_nx = miss + MISS_W'(1);
              end
            end else begin
              miss_nx = '0;
              emit    = 1'b1;
            end
          end
        end
        default: state_nx = HUNT;
      endcase
    end
    // Idle frames reach here too; they simply raise no pulse.
    if (emit) begin
      if (cls == F_DATA) begin
        valid_nx = 1'b1;
        i_nx     = sr_nx[29:17];
        q_nx     = sr_nx[13:1];
      end else if (cls == F_EOM) begin
        eom_nx = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= HUNT;
    else       state <= state_nx;
  end

  // NOTE: the shift register is plain flops, not a memory, so clearing it on
  // reset is cheap and keeps a mid-frame reset from leaving stale bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr        <= '0;
      cnt       <= '0;
      good      <= '0;
      miss      <= '0;
      err_count <= '0;
      out_i     <= '0;
      out_q     <= '0;
      out_valid <= 1'b0;
      out_eom   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (rx_d_valid) sr <= sr_nx;
      cnt       <= cnt_nx;
      good      <= good_nx;
      miss      <= miss_nx;
      err_count <= err_nx;
      out_i     <= i_nx;
      out_q     <= q_nx;
      out_valid <= valid_nx;
      out_eom   <= eom_nx;
      frame_err <= ferr_nx;
    end
  end

endmodule
